// File: rtl/tempsens_cal_loader.sv
// tempsens_cal_loader
//   Serial calibration transmitter for the temperature-sensor macro. A
//   parallel word accepted on start is shifted out MSB-first on
//   CAL_CLK/CAL_DAT while CAL_ENA frames it; CAL_ENA falling commits the
//   word inside the sensor.
// Ports
//   CLK       system clock, rising edge
//   RESET     synchronous, active-low
//   start     send request, honoured only while busy=0
//   data_in   word captured on the accepting edge
//   busy      frame in progress
//   done      one-cycle end-of-frame pulse
//   CAL_CLK   serial clock (sensor samples on its rise)
//   CAL_DAT   serial data, changes only while CAL_CLK is low
//   CAL_ENA   frame enable
module tempsens_cal_loader #(
  parameter int DATA_W  = 12,
  parameter int CLK_DIV = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              CAL_CLK,
  output logic              CAL_DAT,
  output logic              CAL_ENA
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(DATA_W) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, LATCH} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [DATA_W-1:0] sr_shl;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  div_inc;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cal_clk_q, cal_clk_d;
  logic              cal_dat_q, cal_dat_d;
  logic              cal_ena_q, cal_ena_d;
  logic              div_end;

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    div_d     = div_q;
    bit_d     = bit_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cal_clk_d = cal_clk_q;
    cal_dat_d = cal_dat_q;
    cal_ena_d = cal_ena_q;

    sr_shl  = sr_q << 1;
    div_end = (div_q == DIV_LAST);
    // Divider stops at its terminal count; every phase reloads it on exit.
    div_inc = div_end ? div_q : div_q + DIV_W'(1);

    case (state_q)
      IDLE: begin
        if (start && !busy_q) begin
          sr_d      = data_in;
          cal_ena_d = 1'b1;
          cal_clk_d = 1'b0;
          cal_dat_d = data_in[DATA_W-1];
          busy_d    = 1'b1;
          bit_d     = '0;
          div_d     = '0;
          state_d   = LOW;
        end
      end
      LOW: begin
        if (div_end) begin
          cal_clk_d = 1'b1;
          div_d     = '0;
          state_d   = HIGH;
        end else begin
          div_d = div_inc;
        end
      end
      HIGH: begin
        if (div_end) begin
          // Data moves on the CAL_CLK falling edge, giving a full
          // half-period of setup before the next rise.
          cal_clk_d = 1'b0;
          div_d     = '0;
          if (bit_q == BIT_LAST) begin
            cal_dat_d = 1'b0;
            state_d   = LATCH;
          end else begin
            sr_d      = sr_shl;
            cal_dat_d = sr_shl[DATA_W-1];
            bit_d     = bit_q + BIT_W'(1);
            state_d   = LOW;
          end
        end else begin
          div_d = div_inc;
        end
      end
      LATCH: begin
        // CAL_ENA held for one half-period after the last fall so the
        // sensor sees hold time before the commit edge.
        if (div_end) begin
          cal_ena_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          div_d     = '0;
          state_d   = IDLE;
        end else begin
          div_d = div_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cal_clk_q <= 1'b0;
      cal_dat_q <= 1'b0;
      cal_ena_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cal_clk_q <= cal_clk_d;
      cal_dat_q <= cal_dat_d;
      cal_ena_q <= cal_ena_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign CAL_CLK = cal_clk_q;
  assign CAL_DAT = cal_dat_q;
  assign CAL_ENA = cal_ena_q;

endmodule

// File: doc/tempsens_cal_loader.md
# tempsens_cal_loader

Serial calibration transmitter for the temperature-sensor macro's calibration port. It accepts a parallel calibration word with a start strobe and shifts it out MSB-first on the CAL_CLK / CAL_DAT / CAL_ENA three-wire interface. It closes each frame by dropping CAL_ENA, which commits the word inside the sensor. The block sits in the on-chip calibration controller, or on the bench side of the sensor, and drives the sensor's CAL_* inputs directly.

## Interface
- DATA_W, default 12: calibration word width in bits; must be at least 1.
- CLK_DIV, default 4: CLK cycles per CAL_CLK half-period; must be at least 1.
- CLK, input, 1: system clock; all state changes on the rising edge.
- RESET, input, 1: reset, synchronous and active-low.
- start, input, 1: request to send data_in; honoured only while busy=0.
- data_in, input, DATA_W: calibration word; captured on the edge that accepts start.
- busy, output, 1: a frame is in progress.
- done, output, 1: one-cycle pulse marking the end of a frame.
- CAL_CLK, output, 1: serial clock to the sensor; the sensor samples CAL_DAT on its rising edge.
- CAL_DAT, output, 1: serial data, MSB first; changes only while CAL_CLK is low.
- CAL_ENA, output, 1: frame enable; its falling edge commits the word.

## Operation
- All outputs are registered.
- Reset (RESET=0 at an edge): busy=0, done=0, CAL_CLK=0, CAL_DAT=0, CAL_ENA=0, state=IDLE, counters cleared. Reset overrides start in the same cycle.
- IDLE: start=1 and busy=0 at an edge causes:
  - shift register ← data_in;
  - CAL_ENA=1, CAL_CLK=0, CAL_DAT=data_in[DATA_W-1];
  - busy=1, bit counter=0, divider=0;
  - state → LOW.
- LOW: CAL_CLK held 0 for CLK_DIV cycles, then CAL_CLK=1 and state → HIGH.
- HIGH: CAL_CLK held 1 for CLK_DIV cycles, then CAL_CLK=0.
  - If more bits remain: shift left, present the next bit on CAL_DAT, increment the bit counter, state → LOW.
  - After the last bit: CAL_DAT=0, state → LATCH.
- LATCH: CAL_CLK=0 and CAL_ENA=1 held for CLK_DIV cycles (hold time before commit). Then CAL_ENA=0, busy=0, done=1, state → IDLE.
- done is high for exactly one cycle.
- start while busy=1 is ignored; data_in is not re-sampled mid-frame.
- Reset mid-frame: all outputs are forced low at that edge and the frame is abandoned. The sensor sees CAL_ENA fall with a partial word, so the controller must re-send after reset.
- Counters:
  - divider is clog2(CLK_DIV)+1 bits and saturates at CLK_DIV-1;
  - bit counter is clog2(DATA_W)+1 bits;
  - no wrap-around within a frame.

## Timing
- Let edge k be the edge that accepts start.
- Bit i (0 = MSB): CAL_DAT valid from edge k+2·CLK_DIV·i. CAL_CLK rises at edge k+2·CLK_DIV·i+CLK_DIV and falls at edge k+2·CLK_DIV·(i+1).
- CAL_DAT setup and hold around each CAL_CLK rise are CLK_DIV cycles each.
- CAL_ENA is high for edges k through k+2·CLK_DIV·DATA_W+CLK_DIV−1.
- At edge k+2·CLK_DIV·DATA_W+CLK_DIV: CAL_ENA=0, done=1, busy=0.
- Earliest next accepted start is the following edge, giving a minimum CAL_ENA low gap of 1 cycle.
- Exactly DATA_W CAL_CLK rising edges per frame. No CAL_CLK edge occurs while CAL_ENA=0.
- With defaults: 100 cycles of CAL_ENA high per frame, and done at k+100.

## Test plan
- Reset: RESET=0 for 3 cycles with start=1 → all outputs 0 and no frame starts. Release reset with start=0 → outputs stay 0.
- Single frame: DATA_W=12, CLK_DIV=4, data_in=0xA5C, start pulsed at edge k:
  - monitor samples CAL_DAT on 12 CAL_CLK rises and gets 1010_0101_1100;
  - CAL_ENA high for exactly 100 cycles;
  - done=1 only at k+100.
- Start while busy: second start with data_in=0xFFF at k+10 → ignored; the captured word is still 0xA5C; no extra CAL_CLK edges.
- Back-to-back: start held high continuously with 0x001 then 0x800 → second frame accepted at k+101, CAL_ENA low for exactly 1 cycle, decoded words 0x001 and 0x800.
- Reset mid-frame: RESET=0 at k+37 → at that edge CAL_ENA=CAL_CLK=CAL_DAT=busy=0 and done stays 0. A new start after reset release sends a full frame correctly.
- Parameter corner: CLK_DIV=1, DATA_W=1, data_in=1 → CAL_CLK high 1 cycle at k+1, CAL_ENA high 3 cycles, done at k+3.
